// File: rtl/round_key_sequencer.sv
// Round-key index sequencer: arbitrates encrypt/decrypt requests and steps the
// key-RAM select up (encrypt) or down (decrypt) once per datapath advance.
module round_key_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EncReq,
    input  logic             DecReq,
    input  logic             KeyAdv,
    input  logic             Abort,
    output logic [IDX_W-1:0] SelKey,
    output logic             KeyValid,
    output logic             ModeDec,
    output logic             Busy,
    output logic             LastKey,
    output logic             Done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, ENC, DEC, FIN} state_t;

    state_t state;
    logic   pend_valid;
    logic   pend_dec;

    // Launch decision shared by IDLE and FIN; a held pending request beats new ones.
    logic launch;
    logic launch_dec;
    logic next_pend_valid;
    logic next_pend_dec;

    always_comb begin
        launch          = 1'b0;
        launch_dec      = 1'b0;
        next_pend_valid = 1'b0;
        next_pend_dec   = 1'b0;
        if (state == FIN && pend_valid) begin
            launch     = 1'b1;
            launch_dec = pend_dec;
        end else if (EncReq) begin
            launch          = 1'b1;
            launch_dec      = 1'b0;
            next_pend_valid = DecReq;
            next_pend_dec   = 1'b1;
        end else if (DecReq) begin
            launch     = 1'b1;
            launch_dec = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            pend_dec   <= 1'b0;
            SelKey     <= '0;
            KeyValid   <= 1'b0;
            ModeDec    <= 1'b0;
            Busy       <= 1'b0;
            LastKey    <= 1'b0;
            Done       <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Abort) begin
                state      <= IDLE;
                pend_valid <= 1'b0;
                SelKey     <= '0;
                KeyValid   <= 1'b0;
                Busy       <= 1'b0;
                LastKey    <= 1'b0;
            end else begin
                case (state)
                    IDLE, FIN: begin
                        pend_valid <= next_pend_valid;
                        pend_dec   <= next_pend_dec;
                        if (launch) begin
                            state    <= launch_dec ? DEC : ENC;
                            SelKey   <= launch_dec ? LAST_IDX : '0;
                            ModeDec  <= launch_dec;
                            KeyValid <= 1'b1;
                            Busy     <= 1'b1;
                            LastKey  <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            SelKey   <= '0;
                            KeyValid <= 1'b0;
                            Busy     <= 1'b0;
                            LastKey  <= 1'b0;
                        end
                    end
                    ENC, DEC: begin
                        if (!pend_valid && (EncReq || DecReq)) begin
                            pend_valid <= 1'b1;
                            pend_dec   <= !EncReq;
                        end
                        if (KeyAdv) begin
                            if (LastKey) begin
                                state    <= FIN;
                                Done     <= 1'b1;
                                KeyValid <= 1'b0;
                                Busy     <= 1'b0;
                                LastKey  <= 1'b0;
                            end else if (state == ENC) begin
                                SelKey  <= SelKey + IDX_W'(1);
                                LastKey <= (SelKey + IDX_W'(1)) == LAST_IDX;
                            end else begin
                                SelKey  <= SelKey - IDX_W'(1);
                                LastKey <= SelKey == IDX_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
